mux4_rr_scan_ctrl: RTL and testbench

//   Round-robin scheduler that shares one HC153-style 4:1 mux among 4 requesters.

---
 rtl/mux4_scan_pkg.sv | 20 ++
 rtl/mux4_rr_scan_ctrl_if.sv | 29 ++
 rtl/rr_pick4.sv | 38 +++
 rtl/mux4_rr_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_mux4_rr_scan_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mux4_scan_pkg.sv
// Purpose: shared constants, FSM state type and helpers for the 4:1 mux scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux4_scan_pkg;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  // One-hot grant vector for a channel index.
  function automatic logic [N_CH-1:0] ch2onehot(input logic [CH_W-1:0] ch);
    return N_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/mux4_rr_scan_ctrl_if.sv
// Purpose: bundles request, mux-control and sample-report signals of the scan controller.
// Latency: n/a (wires only).
// Backpressure: none; req is level-sensitive and simply waits while the controller is busy.
interface mux4_rr_scan_ctrl_if;
  import mux4_scan_pkg::*;

  logic [N_CH-1:0] req;
  logic            y;
  logic [CH_W-1:0] sel;
  logic            en_n;
  logic [N_CH-1:0] gnt;
  logic            smp_valid;
  logic            smp_data;
  logic [CH_W-1:0] smp_ch;
  logic            busy;

  // Request sources plus the mux datapath (drives req and y).
  modport master (
    output req, y,
    input  sel, en_n, gnt, smp_valid, smp_data, smp_ch, busy
  );

  // The scan controller itself.
  modport slave (
    input  req, y,
    output sel, en_n, gnt, smp_valid, smp_data, smp_ch, busy
  );

endinterface

// File: rtl/rr_pick4.sv
// Purpose: round-robin pick of one of four requests, searching from ptr+1 and wrapping.
// Latency: combinational.
// Backpressure: none.
module rr_pick4
  import mux4_scan_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            any,
  output logic [CH_W-1:0] idx
);

  logic [CH_W-1:0] start;
  logic [N_CH-1:0] rot;
  logic [CH_W-1:0] off;

  assign start = ptr + CH_W'(1);

  // Rotate so that rot[0] is the channel just after the last grant.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_CH; i++) begin
      rot[i] = req[start + CH_W'(i)];
    end
  end

  // Lowest set bit of the rotated vector wins; scan downwards so the lowest overrides.
  always_comb begin
    off = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = CH_W'(i);
    end
  end

  assign any = |rot;
  assign idx = start + off;

endmodule

// File: rtl/mux4_rr_scan_ctrl.sv
// Purpose: round-robin scan of four requesters through one HC153 mux, sampling y per grant.
// Latency: req -> en_n low 1 cycle; req -> smp_valid SETTLE_CYC+2 cycles.
// Backpressure: requests seen outside IDLE wait; a dropped request aborts or ends the grant.
module mux4_rr_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int HOLD_CYC   = 2,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_scan_ctrl_if.slave bus
);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0] gnt_q, gnt_d;
  logic            en_n_q, en_n_d;
  logic            smp_valid_q, smp_valid_d;
  logic            smp_data_q, smp_data_d;
  logic [CH_W-1:0] smp_ch_q, smp_ch_d;
  logic            pick_any;
  logic [CH_W-1:0] pick_idx;

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state and output decode; sel only moves on the IDLE->SETTLE step so it is
  // stable for the whole time the strobe is active.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    en_n_d      = en_n_q;
    smp_valid_d = 1'b0;
    smp_data_d  = smp_data_q;
    smp_ch_d    = smp_ch_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = SETTLE;
          sel_d   = pick_idx;
          gnt_d   = ch2onehot(pick_idx);
          en_n_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!bus.req[sel_q]) begin
          // Requester gave up before the sample: release without reporting.
          state_d = IDLE;
          en_n_d  = 1'b1;
          gnt_d   = '0;
          ptr_d   = sel_q;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYC)) begin
          state_d     = HOLD;
          smp_valid_d = 1'b1;
          smp_data_d  = bus.y;
          smp_ch_d    = sel_q;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!bus.req[sel_q] || cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d = IDLE;
          en_n_d  = 1'b1;
          gnt_d   = '0;
          ptr_d   = sel_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        en_n_d  = 1'b1;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; ptr resets to 3 so channel 0 is served first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= CH_W'(N_CH - 1);
      sel_q       <= '0;
      gnt_q       <= '0;
      en_n_q      <= 1'b1;
      smp_valid_q <= 1'b0;
      smp_data_q  <= 1'b0;
      smp_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      en_n_q      <= en_n_d;
      smp_valid_q <= smp_valid_d;
      smp_data_q  <= smp_data_d;
      smp_ch_q    <= smp_ch_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.en_n      = en_n_q;
  assign bus.gnt       = gnt_q;
  assign bus.smp_valid = smp_valid_q;
  assign bus.smp_data  = smp_data_q;
  assign bus.smp_ch    = smp_ch_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux4_rr_scan_ctrl.sv
// Bench for mux4_rr_scan_ctrl: two instances (settle 1/hold 2 and settle 0/hold 15),
// each driving an HC153 model, checked against a grant-age reference model.
module tb_mux4_rr_scan_ctrl;

  localparam int S0 = 1, H0 = 2, S1 = 0, H1 = 15;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_dat;
  int         n_chk, n_err;

  mux4_rr_scan_ctrl_if bus0 ();
  mux4_rr_scan_ctrl_if bus1 ();

  mux4_rr_scan_ctrl #(.SETTLE_CYC(S0), .HOLD_CYC(H0), .CNT_W(4)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
  );
  mux4_rr_scan_ctrl #(.SETTLE_CYC(S1), .HOLD_CYC(H1), .CNT_W(4)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
  );

  // HC153 model: Y follows the selected input while E is low, otherwise low.
  assign bus0.y = ~bus0.en_n & i_dat[bus0.sel];
  assign bus1.y = ~bus1.en_n & i_dat[bus1.sel];

  // Packed view: {busy, en_n, sel[1:0], gnt[3:0], smp_valid, smp_data, smp_ch[1:0]}
  logic [11:0] out0, out1;
  assign out0 = {bus0.busy, bus0.en_n, bus0.sel, bus0.gnt, bus0.smp_valid, bus0.smp_data, bus0.smp_ch};
  assign out1 = {bus1.busy, bus1.en_n, bus1.sel, bus1.gnt, bus1.smp_valid, bus1.smp_data, bus1.smp_ch};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A grant is described by its age: edges 0..S are the settle window (edge S samples),
  // edges S+1..S+H are the hold window (edge S+H always releases).
  bit         m_act [2];
  logic [1:0] m_ch  [2];
  logic [1:0] m_ptr [2];
  logic [1:0] m_sel [2];
  logic [1:0] m_sc  [2];
  bit         m_sv  [2];
  bit         m_sd  [2];
  int         m_age [2];

  function automatic int s_of(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int h_of(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  task automatic model_step(input int i, input logic rn, input logic [3:0] r);
    bit found;
    int c;
    found = 1'b0;
    c = 0;
    if (!rn) begin
      m_act[i] = 1'b0; m_ptr[i] = 2'd3; m_sel[i] = 2'd0; m_ch[i] = 2'd0;
      m_sv[i] = 1'b0; m_sd[i] = 1'b0; m_sc[i] = 2'd0; m_age[i] = 0;
      return;
    end
    m_sv[i] = 1'b0;
    if (!m_act[i]) begin
      for (int k = 1; k <= 4; k++) begin
        if (!found && r[(int'(m_ptr[i]) + k) % 4]) begin
          found = 1'b1;
          c = (int'(m_ptr[i]) + k) % 4;
        end
      end
      if (found) begin
        m_act[i] = 1'b1; m_ch[i] = 2'(c); m_sel[i] = 2'(c); m_age[i] = 0;
      end
    end else if (!r[m_ch[i]]) begin
      m_act[i] = 1'b0; m_ptr[i] = m_ch[i];
    end else if (m_age[i] == s_of(i)) begin
      m_sv[i] = 1'b1; m_sd[i] = i_dat[m_ch[i]]; m_sc[i] = m_ch[i]; m_age[i]++;
    end else if (m_age[i] == s_of(i) + h_of(i)) begin
      m_act[i] = 1'b0; m_ptr[i] = m_ch[i];
    end else begin
      m_age[i]++;
    end
  endtask

  function automatic logic [11:0] mpack(input int i);
    logic [3:0] g;
    g = m_act[i] ? (4'b0001 << m_ch[i]) : 4'b0000;
    return {m_act[i], ~m_act[i], m_sel[i], g, m_sv[i], m_sd[i], m_sc[i]};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model, clock the DUTs, compare after the edge.
  task automatic step(input logic rn, input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] d);
    rst_n    = rn;
    bus0.req = r0;
    bus1.req = r1;
    i_dat    = d;
    model_step(0, rn, r0);
    model_step(1, rn, r1);
    @(posedge clk);
    #1;
    chk("model0", 32'(out0), 32'(mpack(0)));
    chk("model1", 32'(out1), 32'(mpack(1)));
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  idat;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int ng, gap, viol, run, maxrun;
    bit prev_en;
    logic [1:0] prev_sel;
    logic [3:0] r0, r1;

    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus0.req = 4'h0;
    bus1.req = 4'h0;
    i_dat = 4'h0;

    // Single request on ch2 with I[2]=1, then abort on ch1 and re-arbitration from ptr=1.
    tbl[0]  = '{4'b0100, 4'b0100, 12'hA40};
    tbl[1]  = '{4'b0100, 4'b0100, 12'hA40};
    tbl[2]  = '{4'b0100, 4'b0100, 12'hA4E};
    tbl[3]  = '{4'b0100, 4'b0100, 12'hA46};
    tbl[4]  = '{4'b0000, 4'b0100, 12'h606};
    tbl[5]  = '{4'b0000, 4'b0100, 12'h606};
    tbl[6]  = '{4'b0010, 4'b0100, 12'h926};
    tbl[7]  = '{4'b0010, 4'b0100, 12'h926};
    tbl[8]  = '{4'b0000, 4'b0100, 12'h506};
    tbl[9]  = '{4'b0011, 4'b0100, 12'h816};
    tbl[10] = '{4'b0000, 4'b0100, 12'h406};

    // Reset with all requests asserted.
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 4'hF, 4'hF, 4'hF);
      chk("reset0", 32'(out0), 32'h400);
      chk("reset1", 32'(out1), 32'h400);
    end

    for (int j = 0; j < 11; j++) begin
      step(1'b1, tbl[j].req, tbl[j].req, tbl[j].idat);
      chk($sformatf("vec%0d", j), 32'(out0), 32'(tbl[j].exp));
    end

    // Fairness with all requests held: order 0,1,2,3,0,1, one idle cycle between grants.
    step(1'b0, 4'hF, 4'hF, 4'h0);
    ng = 0; gap = 0; viol = 0; prev_en = 1'b1; prev_sel = 2'd0;
    for (int c = 0; c < 26; c++) begin
      step(1'b1, 4'hF, 4'hF, 4'($urandom));
      if (!bus0.en_n) begin
        if (prev_en) begin
          chk("rr_order", 32'(bus0.sel), 32'(ng % 4));
          if (ng > 0) chk("bbm_gap", 32'(gap), 32'd1);
          ng++;
        end else if (bus0.sel != prev_sel) begin
          viol++;
        end
        gap = 0;
      end else begin
        gap++;
      end
      prev_en  = bus0.en_n;
      prev_sel = bus0.sel;
    end
    chk("sel_stable", 32'(viol), 32'd0);
    chk("rr_grants", 32'(ng), 32'd6);

    // Early release on instance 0; hold-length cap on instance 1 with request held.
    step(1'b0, 4'h0, 4'h0, 4'h0);
    run = 0; maxrun = 0;
    for (int c = 0; c < 44; c++) begin
      step(1'b1, (c < 3) ? 4'b0001 : 4'b0000, 4'b0001, 4'($urandom));
      if (c == 2) chk("hold_entry", 32'(bus0.smp_valid), 32'd1);
      if (c == 3) chk("early_rel", 32'(out0[10:4]), 32'b1000000);
      run = bus1.en_n ? 0 : run + 1;
      if (run > maxrun) maxrun = run;
    end
    chk("hold15_max", 32'(maxrun), 32'd16);

    // Reset in the middle of a ch3 hold, then ch0 must win first.
    step(1'b0, 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 3; c++) step(1'b1, 4'b1000, 4'b1000, 4'hF);
    chk("pre_rst_gnt", 32'(bus0.gnt), 32'b1000);
    step(1'b0, 4'b1000, 4'b1000, 4'hF);
    chk("mid_rst", 32'(out0), 32'h400);
    step(1'b1, 4'b1001, 4'b1001, 4'hF);
    chk("post_rst", 32'(out0), 32'h810);

    // Randomised traffic with sticky requests and occasional resets.
    r0 = 4'($urandom);
    r1 = 4'($urandom);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) r0 = 4'($urandom);
      if ($urandom_range(3) == 0) r1 = 4'($urandom);
      step(($urandom_range(99) != 0), r0, r1, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
